// File: rtl/onehot_arb_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
// Holds the state encoding, the requester count and the rotate/find-first pick function.
package onehot_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N  = 16;
    localparam int ARB_IW = $clog2(ARB_N);

    // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
    function automatic logic [ARB_N-1:0] rr_pick(
        input logic [ARB_N-1:0]  req,
        input logic [ARB_IW-1:0] ptr
    );
        logic [2*ARB_N-1:0] dbl;
        logic [2*ARB_N-1:0] back;
        logic [ARB_N-1:0]   rot;
        logic [ARB_N-1:0]   first;
        dbl   = {req, req} >> ptr;
        rot   = dbl[ARB_N-1:0];
        first = rot & (~rot + 1'b1);
        back  = {first, first} << ptr;
        return back[2*ARB_N-1:ARB_N];
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
// Zero latency; no flow control, o_any qualifies the one-hot and index outputs.
// Backpressure: none, purely combinational.
module rr_pick_comb
    import onehot_arb_pkg::*;
(
    input  logic [ARB_N-1:0]  i_req,
    input  logic [ARB_IW-1:0] i_ptr,
    output logic [ARB_N-1:0]  o_grant,
    output logic [ARB_IW-1:0] o_idx,
    output logic              o_any
);

    logic [ARB_N-1:0] w_grant;

    assign w_grant = rr_pick(i_req, i_ptr);
    assign o_grant = w_grant;
    assign o_any   = |i_req;

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < ARB_N; i++) begin
            if (w_grant[i]) begin
                o_idx = ARB_IW'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held until ack or timeout.
// Latency: one cycle from request to grant; back-to-back regrant on release, no bubble.
// Backpressure: grant holds until grant_ack; TIMEOUT>0 revokes a stalled holder with timeout_err.
module onehot_rr_arbiter
    import onehot_arb_pkg::*;
#(
    parameter int N       = ARB_N,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         grant_ack,
    output logic [N-1:0] grant_onehot,
    output logic         grant_valid,
    output logic         timeout_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IW = $clog2(N);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t    r_state, w_state_nxt;
    logic [N-1:0]  r_grant, w_grant_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_terr;

    logic          w_timeout;
    logic          w_release;
    logic [IW-1:0] w_ptr_inc;
    logic [N-1:0]  w_mask_req;
    logic [IW-1:0] w_pick_ptr;
    logic [N-1:0]  w_pick_oh;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_any;

    // Ack wins over a coinciding timeout, so the timeout only fires without ack.
    assign w_timeout  = (TIMEOUT > 0) && (r_state == GRANT) && !grant_ack && (r_cnt == TO_LAST);
    assign w_release  = (r_state == GRANT) && (grant_ack || w_timeout);
    assign w_ptr_inc  = (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
    // The releasing holder sits out the release cycle only.
    assign w_mask_req = w_release ? (req & ~r_grant) : req;
    assign w_pick_ptr = w_release ? w_ptr_inc : r_ptr;

    rr_pick_comb u_pick (
        .i_req   (w_mask_req),
        .i_ptr   (w_pick_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        if (r_state == IDLE) begin
            if (w_pick_any) begin
                w_state_nxt = GRANT;
                w_grant_nxt = w_pick_oh;
                w_idx_nxt   = w_pick_idx;
                w_cnt_nxt   = '0;
            end
        end else begin
            if (w_release) begin
                w_ptr_nxt = w_ptr_inc;
                if (w_pick_any) begin
                    w_grant_nxt = w_pick_oh;
                    w_idx_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end else if (TIMEOUT > 0) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_terr  <= w_timeout;
        end
    end

    assign grant_onehot = r_grant;
    assign grant_valid  = (r_state == GRANT);
    assign timeout_err  = r_terr;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural arbiter model.
module tb_onehot_rr_arbiter;

    localparam int N  = 16;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         grant_ack = 1'b0;
    logic [N-1:0] grant_onehot;
    logic         grant_valid;
    logic         timeout_err;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    onehot_rr_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .grant_ack    (grant_ack),
        .grant_onehot (grant_onehot),
        .grant_valid  (grant_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the grant, where the search starts, how long it has been held.
    bit m_valid = 1'b0;
    int m_idx   = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_terr  = 1'b0;

    function automatic int search(input logic [N-1:0] r, input int start, input int skip);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (r[j[3:0]] && j != skip) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = 0;
            m_held  = 0;
            m_terr  = 1'b0;
        end else begin
            int w;
            bit rel, to;
            to = 1'b0;
            if (!m_valid) begin
                w = search(req, m_ptr, -1);
                if (w >= 0) begin
                    m_valid = 1'b1;
                    m_idx   = w;
                    m_held  = 1;
                end
            end else begin
                rel = grant_ack;
                if (!grant_ack && m_held == TO) begin
                    rel = 1'b1;
                    to  = 1'b1;
                end
                if (rel) begin
                    m_ptr = (m_idx + 1) % N;
                    w = search(req, m_ptr, m_idx);
                    if (w >= 0) begin
                        m_idx  = w;
                        m_held = 1;
                    end else begin
                        m_valid = 1'b0;
                    end
                end else begin
                    m_held++;
                end
            end
            m_terr = to;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] exp_g;
            exp_g = m_valid ? (16'd1 << m_idx) : 16'd0;
            check("model_grant", grant_onehot, exp_g);
            check("model_valid", grant_valid, m_valid);
            check("model_terr", timeout_err, m_terr);
            check("onehot0", $onehot0(grant_onehot), 1);
        end
    end

    initial begin
        // Reset and idle
        repeat (2) @(negedge clk);
        check("reset_grant", grant_onehot, 0);
        check("reset_valid", grant_valid, 0);
        check("reset_terr", timeout_err, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_valid", grant_valid, 0);
            check("idle_grant", grant_onehot, 0);
        end

        // Two requesters, back-to-back handover, then drain
        req = 16'h0104;
        @(negedge clk);
        check("first_grant", grant_onehot, 16'h0004);
        grant_ack = 1'b1;
        @(negedge clk);
        check("b2b_grant", grant_onehot, 16'h0100);
        check("b2b_valid", grant_valid, 1);
        req = 16'h0000;
        @(negedge clk);
        check("drain_valid", grant_valid, 0);

        // Fairness sweep from a fresh pointer
        grant_ack = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 16'hFFFF;
        grant_ack = 1'b1;
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            check("fair_grant", grant_onehot, 32'd1 << (i % N));
        end
        req = 16'h0000;
        @(negedge clk);
        check("fair_end_valid", grant_valid, 0);

        // Timeout of a lone stalled holder
        grant_ack = 1'b0;
        req = 16'h0020;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("to_hold_grant", grant_onehot, 16'h0020);
            check("to_hold_terr", timeout_err, 0);
        end
        @(negedge clk);
        check("to_revoke_valid", grant_valid, 0);
        check("to_pulse", timeout_err, 1);
        @(negedge clk);
        check("to_regrant", grant_onehot, 16'h0020);
        check("to_pulse_end", timeout_err, 0);

        // Ack in the last allowed cycle beats the timeout
        repeat (TO - 1) @(negedge clk);
        check("coinc_g4", grant_onehot, 16'h0020);
        grant_ack = 1'b1;
        req = 16'h0021;
        @(negedge clk);
        check("coinc_next", grant_onehot, 16'h0001);
        check("coinc_noerr", timeout_err, 0);

        // Holder drops its request mid-grant; grant persists until ack
        grant_ack = 1'b0;
        req = 16'h0000;
        repeat (2) begin
            @(negedge clk);
            check("drop_hold", grant_onehot, 16'h0001);
        end
        grant_ack = 1'b1;
        @(negedge clk);
        check("drop_release", grant_valid, 0);

        // Asynchronous reset mid-grant, then search restarts from index 0
        grant_ack = 1'b0;
        req = 16'h2000;
        @(negedge clk);
        check("pre_rst_grant", grant_onehot, 16'h2000);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_grant", grant_onehot, 0);
        check("async_rst_valid", grant_valid, 0);
        req = 16'hA000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_grant", grant_onehot, 16'h2000);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            else req = N'($urandom & $urandom & $urandom);
            grant_ack = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
